// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - size encodings and FSM states for the data memory access controller
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian store lane merge and load extract/extend (combinational)
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [31:0] shifted;

    always_comb begin
        merged    = old_word;
        shifted   = old_word >> {offset, 3'b000};
        extracted = shifted;
        case (size)
            SZ_BYTE: begin
                merged[{offset, 3'b000} +: 8] = new_data[7:0];
                extracted = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                merged[{offset[1], 4'b0000} +: 16] = new_data[15:0];
                extracted = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                merged    = new_data;
                extracted = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store initiator for a word-addressed data memory with sub-word RMW
// Optional misaligned-access trap: define MISALIGN_TRAP_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 64
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] address,
    output logic [31:0] writeData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] readData
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    state_t      state;
    logic        l_write;
    logic        l_unsigned;
    logic [1:0]  l_size;
    logic [1:0]  l_off;
    logic [31:0] l_wdata;
    logic [1:0]  nsize;
    logic [1:0]  eff_off;
    logic [31:0] merged;
    logic [31:0] extracted;
    logic [31:0] word_idx;
    logic        unused_addr_bits;

    assign busy             = ~req_ready;
    assign word_idx         = {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
    assign unused_addr_bits = ^req_addr[31:IDX_W+2];

`ifdef MISALIGN_TRAP_EN
    logic misalign;

    always_comb begin
        nsize    = req_size[1] ? SZ_WORD : req_size;
        eff_off  = req_addr[1:0];
        misalign = ((nsize == SZ_HALF) && req_addr[0]) ||
                   ((nsize == SZ_WORD) && (req_addr[1:0] != 2'b00));
    end
`else
    // Without the trap, misaligned halves/words are silently forced onto their natural boundary.
    always_comb begin
        nsize = req_size[1] ? SZ_WORD : req_size;
        case (nsize)
            SZ_HALF: eff_off = {req_addr[1], 1'b0};
            SZ_WORD: eff_off = 2'b00;
            default: eff_off = req_addr[1:0];
        endcase
    end

    assign resp_err = 1'b0;
`endif

    mem_lane_align u_align (
        .old_word    (readData),
        .new_data    (l_wdata),
        .size        (l_size),
        .offset      (l_off),
        .is_unsigned (l_unsigned),
        .merged      (merged),
        .extracted   (extracted)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
            resp_err   <= 1'b0;
`endif
            memRead    <= 1'b0;
            memWrite   <= 1'b0;
            address    <= '0;
            writeData  <= '0;
            l_write    <= 1'b0;
            l_unsigned <= 1'b0;
            l_size     <= SZ_BYTE;
            l_off      <= 2'b00;
            l_wdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        l_write    <= req_write;
                        l_unsigned <= req_unsigned;
                        l_size     <= nsize;
                        l_off      <= eff_off;
                        l_wdata    <= req_wdata;
                        address    <= word_idx;
                        req_ready  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                        if (misalign) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else
`endif
                        if (req_write && (nsize == SZ_WORD)) begin
                            state     <= ST_WR;
                            memWrite  <= 1'b1;
                            writeData <= req_wdata;
                        end else begin
                            state   <= ST_RD;
                            memRead <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    memRead <= 1'b0;
                    if (l_write) begin
                        state     <= ST_WR;
                        memWrite  <= 1'b1;
                        writeData <= merged;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= extracted;
                    end
                end
                ST_WR: begin
                    memWrite   <= 1'b0;
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
                    resp_err   <= 1'b0;
`endif
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl with a behavioural memory
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData;

    logic [31:0] mem [0:63];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    mem_access_ctrl #(.MEM_WORDS(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .busy         (busy),
        .address      (address),
        .writeData    (writeData),
        .memWrite     (memWrite),
        .memRead      (memRead),
        .readData     (readData)
    );

    always #5 clock = ~clock;

    assign readData = memRead ? mem[address[5:0]] : 32'h0;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (memWrite) mem[address[5:0]] = writeData;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"}, {31'b0, req_ready}, 32'd1);
        check({pfx, "_busy"}, {31'b0, busy}, 32'd0);
        check({pfx, "_rvalid"}, {31'b0, resp_valid}, 32'd0);
        check({pfx, "_rdata"}, resp_rdata, 32'd0);
        check({pfx, "_err"}, {31'b0, resp_err}, 32'd0);
        check({pfx, "_memrd"}, {31'b0, memRead}, 32'd0);
        check({pfx, "_memwr"}, {31'b0, memWrite}, 32'd0);
        check({pfx, "_addr"}, address, 32'd0);
        check({pfx, "_wdata"}, writeData, 32'd0);
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nwr, output logic [31:0] waddr, output logic [31:0] wdat,
                          output int nrd, output logic [31:0] raddr);
        int guard;
        guard = 0;
        nwr = 0; nrd = 0; waddr = '0; wdat = '0; raddr = '0; rdata = '0; err = 1'b0;
        @(negedge clock);
        while (!req_ready && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 10) check("ready_timeout", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clock);
        lat = 0;
        while (lat < 10) begin
            @(negedge clock);
            if (lat == 0) req_valid = 1'b0;
            lat++;
            if (memWrite) begin nwr++; waddr = address; wdat = writeData; end
            if (memRead) begin nrd++; raddr = address; end
            if (resp_valid) begin
                rdata = resp_rdata;
                err = resp_err;
                break;
            end
        end
        if (lat >= 10) check("resp_timeout", {31'b0, resp_valid}, 32'd1);
    endtask

    logic [31:0] rd, wa, wd, ra;
    logic        er;
    int          lt, nw, nr;
    int          acc [4];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b0;

        // 1: word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, rd, er, lt, nw, wa, wd, nr, ra);
        check("sw_lat", lt, 2);
        check("sw_nwr", nw, 1);
        check("sw_addr", wa, 32'd2);
        check("sw_wdata", wd, 32'hDEADBEEF);
        check("sw_rdata", rd, 32'h0);
        check("sw_mem", mem[2], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, rd, er, lt, nw, wa, wd, nr, ra);
        check("lw_lat", lt, 2);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_nwr", nw, 0);
        check("lw_nrd", nr, 1);

        // 2: byte store RMW and byte loads
        mem[1] = 32'h11223344;
        do_req(1'b1, 2'b00, 1'b0, 32'h06, 32'h000000AA, rd, er, lt, nw, wa, wd, nr, ra);
        check("sb_lat", lt, 3);
        check("sb_nwr", nw, 1);
        check("sb_wdata", wd, 32'h11AA3344);
        check("sb_addr", wa, 32'd1);
        do_req(1'b0, 2'b00, 1'b0, 32'h06, 32'h0, rd, er, lt, nw, wa, wd, nr, ra);
        check("lb", rd, 32'hFFFFFFAA);
        do_req(1'b0, 2'b00, 1'b1, 32'h06, 32'h0, rd, er, lt, nw, wa, wd, nr, ra);
        check("lbu", rd, 32'h000000AA);

        // 3: half loads and half store
        mem[3] = 32'h80017FFF;
        do_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, rd, er, lt, nw, wa, wd, nr, ra);
        check("lh", rd, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, rd, er, lt, nw, wa, wd, nr, ra);
        check("lhu", rd, 32'h00007FFF);
        do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'hFFFF1234, rd, er, lt, nw, wa, wd, nr, ra);
        check("sh_lat", lt, 3);
        check("sh_mem", mem[3], 32'h12347FFF);

        // 4: reset while the RMW read is in flight
        mem[5] = 32'h55667788;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h00000099;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("abort_in_rd", {31'b0, memRead}, 32'd1);
        reset = 1'b1;
        nw = 0;
        @(negedge clock);
        check_reset_outputs("abort");
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (memWrite) nw++;
        end
        check("abort_nwr", nw, 0);
        check("abort_mem", mem[5], 32'h55667788);

        // 5: misaligned word load with address wrap
        mem[0] = 32'hCAFEF00D;
        do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rd, er, lt, nw, wa, wd, nr, ra);
`ifdef MISALIGN_TRAP_EN
        check("mis_lw_err", {31'b0, er}, 32'd1);
        check("mis_lw_lat", lt, 1);
        check("mis_lw_nrd", nr, 0);
        check("mis_lw_rdata", rd, 32'h0);
`else
        check("mis_lw_err", {31'b0, er}, 32'd0);
        check("mis_lw_lat", lt, 2);
        check("mis_lw_addr", ra, 32'd0);
        check("mis_lw_rdata", rd, 32'hCAFEF00D);
`endif
        do_req(1'b0, 2'b01, 1'b1, 32'h0F, 32'h0, rd, er, lt, nw, wa, wd, nr, ra);
`ifdef MISALIGN_TRAP_EN
        check("mis_lh_err", {31'b0, er}, 32'd1);
        check("mis_lh_nrd", nr, 0);
`else
        check("mis_lh_rdata", rd, 32'h00001234);
        check("mis_lh_err", {31'b0, er}, 32'd0);
`endif

        // 6: req_valid held high across four word stores
        for (int k = 0; k < 4; k++) begin
            int g;
            g = 0;
            @(negedge clock);
            while (!req_ready && g < 10) begin
                @(negedge clock);
                g++;
            end
            if (g >= 10) check("stream_ready_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
            req_addr = 32'h20 + 32'(4 * k);
            req_wdata = 32'hA5A50000 + 32'(k);
            acc[k] = cyc;
            @(negedge clock);
            check($sformatf("stream_busy%0d", k), {31'b0, busy}, 32'd1);
        end
        repeat (3) @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        for (int k = 1; k < 4; k++)
            check($sformatf("stream_gap%0d", k), acc[k] - acc[k-1], 32'd3);
        for (int k = 0; k < 4; k++)
            check($sformatf("stream_mem%0d", k), mem[8 + k], 32'hA5A50000 + 32'(k));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
